// File: rtl/soin_btb_bimodal_predictor.sv
// Direct-mapped BTB with 2-bit bimodal counters and a circular return-address stack.
// Prediction is combinational from the registered lookup PC; training arrives from execute.
module soin_btb_bimodal_predictor #(
  parameter int unsigned IDX_W       = 8,
  parameter int unsigned TAG_W       = 10,
  parameter int unsigned RAS_DEPTH_L = 3,
  localparam int unsigned META_W     = 1 + 2 + RAS_DEPTH_L + IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [31:0]       fetch_PC,
  input  logic              fetch_redirect,
  input  logic [31:0]       fetch_redirect_PC,
  output logic [31:0]       p_target,
  output logic              p_dir,
  output logic [META_W-1:0] p_meta,
  input  logic              ex_update,
  input  logic [31:0]       ex_PC,
  input  logic [31:0]       ex_target,
  input  logic              ex_dir,
  input  logic [1:0]        ex_type,
  input  logic [META_W-1:0] ex_meta,
  input  logic              ras_recover
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned RAS_N   = 1 << RAS_DEPTH_L;

  localparam logic [1:0] TYPE_COND = 2'b00;
  localparam logic [1:0] TYPE_CALL = 2'b10;
  localparam logic [1:0] TYPE_RET  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [29:0]      target;
    logic [1:0]       br_type;
    logic [1:0]       ctr;
  } btb_entry_t;

  localparam btb_entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0,
                                       br_type: 2'b00, ctr: 2'b01};

  btb_entry_t               btb_q [ENTRIES];
  logic [31:0]              ras_q [RAS_N];
  logic [RAS_DEPTH_L-1:0]   ras_ptr_q, ras_ptr_d;
  logic [31:0]              l_pc_q, l_pc_d;

  logic [IDX_W-1:0]         l_idx;
  logic [TAG_W-1:0]         l_tag;
  btb_entry_t               rd_entry;
  logic                     l_hit;
  logic [31:0]              seq_pc;

  logic                     ras_push, ras_pop, ras_wr_en;
  logic [RAS_DEPTH_L-1:0]   ras_wr_ptr;

  logic                     ex_hit;
  logic [1:0]               ex_ctr;
  logic [1:0]               upd_ctr;
  logic                     btb_wr_en;
  logic [IDX_W-1:0]         btb_wr_idx;
  btb_entry_t               btb_wr_entry;

  // Lookup and prediction from the registered fetch PC
  always_comb begin
    l_idx    = l_pc_q[IDX_W+1:2];
    l_tag    = l_pc_q[IDX_W+TAG_W+1:IDX_W+2];
    rd_entry = btb_q[l_idx];
    l_hit    = rd_entry.valid && (rd_entry.tag == l_tag);
    seq_pc   = l_pc_q + 32'd4;
    p_dir    = l_hit && ((rd_entry.br_type != TYPE_COND) || rd_entry.ctr[1]);
    p_meta   = {l_hit, (l_hit ? rd_entry.ctr : 2'b00), ras_ptr_q, l_idx};
    p_target = seq_pc;
    if (fetch_redirect) begin
      p_target = fetch_redirect_PC;
    end else if (!p_dir) begin
      p_target = seq_pc;
    end else if (rd_entry.br_type == TYPE_RET) begin
      p_target = ras_q[ras_ptr_q];
    end else begin
      p_target = {rd_entry.target, 2'b00};
    end
  end

  // Speculative RAS movement; recovery from execute wins and leaves entries alone
  always_comb begin
    ras_push   = !stall && !fetch_redirect && p_dir && (rd_entry.br_type == TYPE_CALL);
    ras_pop    = !stall && !fetch_redirect && p_dir && (rd_entry.br_type == TYPE_RET);
    ras_wr_en  = ras_push && !ras_recover;
    ras_wr_ptr = ras_ptr_q + RAS_DEPTH_L'(1);
    ras_ptr_d  = ras_ptr_q;
    if (ras_recover) begin
      ras_ptr_d = ex_meta[IDX_W +: RAS_DEPTH_L];
    end else if (ras_push) begin
      ras_ptr_d = ras_ptr_q + RAS_DEPTH_L'(1);
    end else if (ras_pop) begin
      ras_ptr_d = ras_ptr_q - RAS_DEPTH_L'(1);
    end
    l_pc_d = stall ? l_pc_q : fetch_PC;
  end

  // Training write; a not-taken conditional that missed is not worth an entry
  always_comb begin
    ex_hit = ex_meta[META_W-1];
    ex_ctr = ex_meta[META_W-2 -: 2];
    if (!ex_hit) begin
      upd_ctr = ex_dir ? 2'b10 : 2'b01;
    end else if (ex_dir) begin
      upd_ctr = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'b01;
    end else begin
      upd_ctr = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'b01;
    end
    btb_wr_en            = ex_update && !((ex_type == TYPE_COND) && !ex_dir && !ex_hit);
    btb_wr_idx           = ex_PC[IDX_W+1:2];
    btb_wr_entry.valid   = 1'b1;
    btb_wr_entry.tag     = ex_PC[IDX_W+TAG_W+1:IDX_W+2];
    btb_wr_entry.target  = ex_target[31:2];
    btb_wr_entry.br_type = ex_type;
    btb_wr_entry.ctr     = upd_ctr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_pc_q    <= '0;
      ras_ptr_q <= '0;
      for (int unsigned i = 0; i < RAS_N; i++) begin
        ras_q[i] <= '0;
      end
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= ENTRY_RST;
      end
    end else begin
      l_pc_q    <= l_pc_d;
      ras_ptr_q <= ras_ptr_d;
      if (ras_wr_en) begin
        ras_q[ras_wr_ptr] <= seq_pc;
      end
      if (btb_wr_en) begin
        btb_q[btb_wr_idx] <= btb_wr_entry;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ex_PC[31:IDX_W+TAG_W+2], ex_PC[1:0], ex_target[1:0],
                         ex_meta[IDX_W-1:0]};

endmodule

// File: tb/tb_soin_btb_bimodal_predictor.sv
// Bench for the BTB/bimodal/RAS predictor: directed scenarios plus random traffic,
// all checked against an array-based reference model of the predictor's rules.
module tb_soin_btb_bimodal_predictor;

  localparam int unsigned IDX_W  = 8;
  localparam int unsigned TAG_W  = 10;
  localparam int unsigned RD     = 3;
  localparam int unsigned META_W = 1 + 2 + RD + IDX_W;
  localparam int unsigned N      = 1 << IDX_W;
  localparam int unsigned D      = 1 << RD;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic [31:0]       fetch_PC;
  logic              fetch_redirect;
  logic [31:0]       fetch_redirect_PC;
  logic [31:0]       p_target;
  logic              p_dir;
  logic [META_W-1:0] p_meta;
  logic              ex_update;
  logic [31:0]       ex_PC;
  logic [31:0]       ex_target;
  logic              ex_dir;
  logic [1:0]        ex_type;
  logic [META_W-1:0] ex_meta;
  logic              ras_recover;

  soin_btb_bimodal_predictor #(.IDX_W(IDX_W), .TAG_W(TAG_W), .RAS_DEPTH_L(RD)) dut (
    .clk(clk), .reset(reset), .stall(stall), .fetch_PC(fetch_PC),
    .fetch_redirect(fetch_redirect), .fetch_redirect_PC(fetch_redirect_PC),
    .p_target(p_target), .p_dir(p_dir), .p_meta(p_meta),
    .ex_update(ex_update), .ex_PC(ex_PC), .ex_target(ex_target), .ex_dir(ex_dir),
    .ex_type(ex_type), .ex_meta(ex_meta), .ras_recover(ras_recover)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          mv   [N];
  int unsigned mtag [N];
  logic [31:0] mtgt [N];
  int unsigned mty  [N];
  int unsigned mctr [N];
  logic [31:0] mras [D];
  int unsigned mrp;
  logic [31:0] mlpc;

  logic              e_hit, e_dir;
  logic [31:0]       e_tgt;
  logic [META_W-1:0] e_meta;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] pool [12] = '{32'h100, 32'h500, 32'h300, 32'h480, 32'h104, 32'h108,
                             32'h1000, 32'hABC0, 32'h40100, 32'h304, 32'h7FC, 32'h900};
  logic [META_W-1:0] hist [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < int'(N); i++) begin
      mv[i] = 1'b0; mtag[i] = 0; mtgt[i] = '0; mty[i] = 0; mctr[i] = 1;
    end
    for (int i = 0; i < int'(D); i++) mras[i] = '0;
    mrp  = 0;
    mlpc = '0;
  endfunction

  function automatic void model_eval();
    int unsigned idx, tg;
    idx   = (mlpc >> 2) % N;
    tg    = (mlpc >> (IDX_W + 2)) % (1 << TAG_W);
    e_hit = mv[idx] && (mtag[idx] == tg);
    e_dir = e_hit && ((mty[idx] != 0) || (mctr[idx] >= 2));
    if (fetch_redirect)   e_tgt = fetch_redirect_PC;
    else if (!e_dir)      e_tgt = mlpc + 32'd4;
    else if (mty[idx]==3) e_tgt = mras[mrp];
    else                  e_tgt = mtgt[idx];
    e_meta = {e_hit, 2'(e_hit ? mctr[idx] : 0), RD'(mrp), IDX_W'(idx)};
  endfunction

  function automatic void model_step();
    int unsigned idx, ui, mc;
    logic hm;
    idx = (mlpc >> 2) % N;
    if (ras_recover) begin
      mrp = int'(ex_meta[IDX_W +: RD]);
    end else if (!stall && !fetch_redirect && e_dir) begin
      if (mty[idx] == 2) begin
        mrp = (mrp + 1) % D;
        mras[mrp] = mlpc + 32'd4;
      end else if (mty[idx] == 3) begin
        mrp = (mrp + D - 1) % D;
      end
    end
    hm = ex_meta[META_W-1];
    mc = int'(ex_meta[META_W-2 -: 2]);
    if (ex_update && !(ex_type == 2'b00 && !ex_dir && !hm)) begin
      ui       = (ex_PC >> 2) % N;
      mv[ui]   = 1'b1;
      mtag[ui] = (ex_PC >> (IDX_W + 2)) % (1 << TAG_W);
      mtgt[ui] = {ex_target[31:2], 2'b00};
      mty[ui]  = int'(ex_type);
      if (hm) mctr[ui] = ex_dir ? ((mc == 3) ? 3 : mc + 1) : ((mc == 0) ? 0 : mc - 1);
      else    mctr[ui] = ex_dir ? 2 : 1;
    end
    if (!stall) mlpc = fetch_PC;
  endfunction

  // One clock: compare outputs against the model, advance the model, move to next negedge
  task automatic cycle();
    #1;
    model_eval();
    check_eq("p_dir", 32'(p_dir), 32'(e_dir));
    check_eq("p_target", p_target, e_tgt);
    check_eq("p_meta", 32'(p_meta), 32'(e_meta));
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; fetch_PC = '0; fetch_redirect = 1'b0; fetch_redirect_PC = '0;
    ex_update = 1'b0; ex_PC = '0; ex_target = '0; ex_dir = 1'b0; ex_type = 2'b00;
    ex_meta = '0; ras_recover = 1'b0;
  endtask

  task automatic rst_pulse();
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_p_dir", 32'(p_dir), 32'd0);
    check_eq("rst_p_target", p_target, 32'h4);
    check_eq("rst_p_meta", 32'(p_meta), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] ras_fld();
    return 32'(p_meta[IDX_W +: RD]);
  endfunction

  initial begin
    int unsigned rp0;
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_p_dir", 32'(p_dir), 32'd0);
    check_eq("reset_p_target", p_target, 32'h4);
    check_eq("reset_p_meta", 32'(p_meta), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Cold miss
    fetch_PC = 32'h100;
    cycle();
    check_eq("cold_dir", 32'(p_dir), 32'd0);
    check_eq("cold_target", p_target, 32'h104);
    check_eq("cold_hit", 32'(p_meta[META_W-1]), 32'd0);

    // Conditional training, same-cycle update and lookup
    ex_update = 1'b1; ex_PC = 32'h100; ex_type = 2'b00; ex_dir = 1'b1;
    ex_target = 32'h200; ex_meta = '0;
    cycle();
    check_eq("train_dir", 32'(p_dir), 32'd1);
    check_eq("train_target", p_target, 32'h200);
    check_eq("train_ctr", 32'(p_meta[META_W-2 -: 2]), 32'd2);
    ex_dir = 1'b0;
    repeat (2) begin
      model_eval();
      ex_meta = e_meta;
      cycle();
    end
    check_eq("nt_dir", 32'(p_dir), 32'd0);
    check_eq("nt_ctr", 32'(p_meta[META_W-2 -: 2]), 32'd0);
    model_eval();
    ex_meta = e_meta;
    cycle();
    check_eq("sat_ctr", 32'(p_meta[META_W-2 -: 2]), 32'd0);
    ex_update = 1'b0;

    // Call and return
    ex_update = 1'b1; ex_PC = 32'h300; ex_type = 2'b10; ex_dir = 1'b1;
    ex_target = 32'h400; ex_meta = '0;
    cycle();
    ex_PC = 32'h480; ex_type = 2'b11; ex_target = 32'h0;
    cycle();
    ex_update = 1'b0;
    fetch_PC = 32'h300;
    cycle();
    check_eq("call_target", p_target, 32'h400);
    rp0 = ras_fld();
    fetch_PC = 32'h480;
    cycle();
    check_eq("ret_target", p_target, 32'h304);
    fetch_PC = 32'h100;
    cycle();
    check_eq("ret_ptr", ras_fld(), rp0);

    // RAS wrap after nine calls
    fetch_PC = 32'h300;
    repeat (10) cycle();
    check_eq("wrap_ptr", ras_fld(), (rp0 + 9) % D);

    // Recovery overrides a simultaneous push
    ras_recover = 1'b1;
    ex_meta = {1'b0, 2'b00, 3'd2, 8'd0};
    cycle();
    ras_recover = 1'b0;
    check_eq("recover_ptr", ras_fld(), 32'd2);

    // Redirect during a predicted call
    fetch_redirect = 1'b1; fetch_redirect_PC = 32'h800;
    #1;
    check_eq("redir_target", p_target, 32'h800);
    cycle();
    fetch_redirect = 1'b0;
    check_eq("redir_no_push", ras_fld(), 32'd2);

    // Stall freezes lookup and RAS; training continues
    stall = 1'b1;
    ex_update = 1'b1; ex_PC = 32'h600; ex_type = 2'b01; ex_dir = 1'b1;
    ex_target = 32'h700; ex_meta = '0;
    repeat (3) begin
      fetch_PC = $urandom & 32'hFFFF_FFFC;
      cycle();
      check_eq("stall_target", p_target, 32'h400);
      check_eq("stall_ptr", ras_fld(), 32'd2);
    end
    stall = 1'b0; ex_update = 1'b0;
    fetch_PC = 32'h600;
    cycle();
    check_eq("stall_upd_dir", 32'(p_dir), 32'd1);
    check_eq("stall_upd_target", p_target, 32'h700);

    // Alias: same index, different tag
    fetch_PC = 32'h100 + (32'd4 << IDX_W);
    cycle();
    check_eq("alias_hit", 32'(p_meta[META_W-1]), 32'd0);
    check_eq("alias_dir", 32'(p_dir), 32'd0);

    // Reset in the middle of operation
    rst_pulse();
    cycle();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      stall             = ($urandom % 5 == 0);
      fetch_PC          = pool[$urandom % 12];
      fetch_redirect    = ($urandom % 10 == 0);
      fetch_redirect_PC = $urandom;
      ex_update         = ($urandom % 2 == 0);
      ex_PC             = pool[$urandom % 12];
      ex_target         = $urandom;
      ex_dir            = ($urandom % 3 != 0);
      ex_type           = 2'($urandom % 4);
      ex_meta           = ($urandom % 4 != 0) ? hist[$urandom % 8] : META_W'($urandom);
      ras_recover       = ($urandom % 20 == 0);
      model_eval();
      hist[k % 8] = e_meta;
      cycle();
      if ($urandom % 400 == 0) rst_pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/soin_btb_bimodal_predictor.md
SOIN_BTB_BIMODAL_PREDICTOR -- requirements
Module: soin_btb_bimodal_predictor

Interface
REQ-001 SHALL have parameters: IDX_W, default 8, BTB/counter index width (2**IDX_W entries); TAG_W, default 10, stored tag width; RAS_DEPTH_L, default 3, RAS depth log2 (2**RAS_DEPTH_L entries).
REQ-002 SHALL derive META_W = 1+2+RAS_DEPTH_L+IDX_W; meta layout {hit, ctr[1:0], ras_ptr, idx}, idx in LSBs.
REQ-003 SHALL have one clock and an asynchronous active-low reset, with ports as follows (clock and reset first):
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low.
- stall  input  1  freeze lookup pipeline and RAS speculation.
- fetch_PC  input  32  PC of next fetch (sampled at edge).
- fetch_redirect  input  1  fetch being redirected this cycle.
- fetch_redirect_PC  input  32  redirect target.
- p_target  output  32  predicted next PC.
- p_dir  output  1  predicted taken.
- p_meta  output  META_W  snapshot for execute.
- ex_update  input  1  execute resolved a control-flow instruction.
- ex_PC  input  32  its PC.
- ex_target  input  32  its resolved target.
- ex_dir  input  1  resolved taken.
- ex_type  input  2  00 cond, 01 uncond jump, 10 call, 11 return.
- ex_meta  input  META_W  p_meta returned with that instruction.
- ras_recover  input  1  restore RAS pointer from ex_meta.

Function
REQ-004 Lookup: on a rising edge with stall=0, SHALL register fetch_PC as L_PC; idx = L_PC[IDX_W+1:2], tag = L_PC[IDX_W+TAG_W+1:IDX_W+2]; with stall=1, L_PC SHALL hold.
REQ-005 Prediction SHALL be combinational from L_PC and current table state: valid one cycle after fetch_PC presented.
REQ-006 Entry SHALL hold valid, tag, target[31:2], type[1:0], ctr[1:0]; hit = valid & tag match.
REQ-007 p_dir SHALL = hit & (type!=00 | ctr[1]).
REQ-008 p_target priority: fetch_redirect -> fetch_redirect_PC; else !p_dir -> L_PC+4; else type=11 -> RAS top; else {target,2'b00}.
REQ-009 p_meta SHALL = {hit, ctr, ras_ptr before this cycle's push/pop, idx}.
REQ-010 RAS push: edge with stall=0, fetch_redirect=0, p_dir=1, type=10 SHALL write L_PC+4 at ras_ptr+1 and ras_ptr<=ras_ptr+1; top = entry[ras_ptr].
REQ-011 RAS pop: same qualifiers with type=11 SHALL ras_ptr<=ras_ptr-1.
REQ-012 ras_ptr SHALL wrap modulo 2**RAS_DEPTH_L; overflow overwrites oldest, underflow returns stale entry; no full/empty flags.
REQ-013 ras_recover=1 SHALL set ras_ptr<=ex_meta ras_ptr field, overriding any same-cycle push/pop (entries untouched).
REQ-014 Update: ex_update=1 at edge SHALL write entry ex_PC[IDX_W+1:2]: valid=1, tag, target=ex_target[31:2], type=ex_type, ctr per REQ-015.
REQ-015 ctr: if ex_meta.hit: saturating +1 on ex_dir=1 (max 11), -1 on ex_dir=0 (min 00), from ex_meta.ctr; if !hit: 10 if ex_dir else 01.
REQ-016 ex_update with ex_type=00, ex_dir=0, ex_meta.hit=0 SHALL NOT allocate (no write).
REQ-017 Same-cycle update and lookup of same index: the lookup registered that edge SHALL see updated contents on the following cycle (no same-cycle bypass).
REQ-018 stall SHALL NOT block ex_update or ras_recover.

Reset
REQ-019 reset=0 SHALL asynchronously clear all valid bits, all ctr to 01, ras_ptr and RAS entries to 0, L_PC to 0.
REQ-020 During/after reset until first fetch: p_dir=0, p_meta=0, p_target=32'h4 (fetch_redirect=0).
REQ-021 Reset deassertion mid-operation SHALL discard all speculative and learned state; no partial updates persist.

Verification
REQ-022 Cold miss: reset, fetch_PC=0x100 -> next cycle p_dir=0, p_target=0x104, p_meta.hit=0.
REQ-023 Train cond: ex_update PC=0x100, type=00, dir=1, target=0x200, meta.hit=0 -> fetch 0x100: p_dir=1, ctr=10, p_target=0x200; two not-taken updates with returned meta -> ctr 00, p_dir=0; further not-taken holds 00.
REQ-024 Call/return: call at 0x300 (target 0x400), return at 0x480 trained; fetch 0x300 -> push 0x304; fetch 0x480 -> p_target=0x304, ras_ptr back to original.
REQ-025 RAS wrap: 9 predicted calls with RAS_DEPTH_L=3 -> ras_ptr wraps to 1, oldest entry overwritten; ras_recover with meta ras_ptr=2 -> ras_ptr=2 despite simultaneous push.
REQ-026 Redirect/stall: fetch_redirect=1, fetch_redirect_PC=0x800 while hit -> p_target=0x800, no RAS push; stall=1 for 3 cycles -> outputs and ras_ptr constant, while ex_update still writes table.
REQ-027 Alias: update ex_PC=0x100 then lookup 0x100+(4<<IDX_W)... tag differs -> hit=0, p_dir=0.
